mmio_region_router: RTL and testbench
=====================================

# mmio_region_router

Parametrised data-side address router between the core's load/store port, the shared cached RAM, and N memory-mapped peripheral channels. It decodes kernel/program RAM and an MMIO window split into equal-stride channels, and stalls the core while RAM is busy or a peripheral has not acknowledged. It returns read data one cycle after the access completes and flags timeouts and unmapped accesses. It replaces the fixed UART/display decode in the memory controller with a generic multi-channel, multi-cycle-capable fabric.

## Interface
Parameters:
- N_CH, 4, number of MMIO channels (1..16)
- CH_STRIDE, 'h400, bytes per channel window (power of two)
- MMIO_BASE, 32'haaaaa000, base of channel 0
- TIMEOUT, 64, max wait cycles for mmio_ack before abort (>=1)
- ERR_DATA, 32'hdeadbeef, read data returned on error

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_rea / mem_wea  in  1  core read / write request (held stable while mem_hold=1)
- mem_en  in  4  byte enables
- mem_addr  in  32  byte address
- mem_din  in  32  write data
- mem_dout  out  32  read data, valid the cycle after completion
- mem_hold  out  1  stall core
- mem_err  out  1  one-cycle error pulse, aligned with mem_dout
- err_cnt  out  8  saturating error count
- ram_en  out  1  RAM access strobe
- ram_we  out  4  RAM byte write enables
- ram_dout  in  32  RAM read data (1-cycle latency)
- ram_busy  in  1  cache not ready
- ch_req  out  N_CH  per-channel request, level until ack or abort
- ch_we  out  1  write qualifier; ch_addr  out  log2(CH_STRIDE)  offset; ch_wdata  out  32
- ch_rdata  in  32*N_CH  channel read data, valid with ack
- ch_ack  in  N_CH  channel acknowledge

## Operation
- Decode: RAM if mem_addr[31:16] is 16'h0000 or 16'h0001. Channel k if MMIO_BASE + k*CH_STRIDE <= addr < MMIO_BASE + (k+1)*CH_STRIDE, k < N_CH. Anything else is unmapped.
- FSM states: IDLE, CH_WAIT, ABORT.
- IDLE, RAM access:
  - ram_busy=1: mem_hold=1, ram_en=0.
  - Otherwise ram_en=1, ram_we = mem_wea ? mem_en : 0, no hold. Next cycle mem_dout=ram_dout.
- IDLE, channel k: ch_req[k]=1 combinationally.
  - ch_ack[k] in the same cycle: completes with no hold; ch_rdata[k] is captured.
  - Otherwise mem_hold=1 and the FSM goes to CH_WAIT with the wait counter cleared.
- CH_WAIT:
  - ch_req[k] stays high; mem_hold = ~ch_ack[k].
  - On ack: capture data, return to IDLE.
  - Counter reaching TIMEOUT-1 without ack: go to ABORT (ch_req drops).
- ABORT: mem_hold=0 for one cycle (access retires), return to IDLE. Next cycle: mem_dout=ERR_DATA, mem_err=1.
- Unmapped access: no hold, no strobes, writes dropped. Next cycle: mem_dout=ERR_DATA, mem_err=1.
- err_cnt increments on each mem_err pulse and saturates at 255.
- ch_ack on a channel that is not requested is ignored.
- A response-select register (RAM/channel/error) chooses the mem_dout source one cycle after completion. It holds its value when there is no access.

## Timing
- Reset (async, rst_n=0): state=IDLE; mem_hold, mem_err, ram_en, ram_we, ch_req, ch_we, err_cnt = 0; mem_dout=0; counter=0.
- Reset mid-wait: ch_req drops immediately and the access is lost.
- Read latency: data appears one cycle after the last cycle in which mem_hold=0 with the request present.
- Zero-wait channel: 0 hold cycles. A channel acking on wait cycle w: hold lasts w cycles.
- Timeout: exactly TIMEOUT hold cycles, then 1 retire cycle, then the error pulse.
- Back-to-back accesses: a new access may decode in the same cycle the previous response is driven.
- ram_busy rising during CH_WAIT has no effect on channel traffic.

## Structure
- Package mmio_pkg: state enum, response-select enum, default constants MMIO_BASE and ERR_DATA, and the RAM region IDs.
- Sub-module mmio_addr_decode: combinational decode producing a RAM hit, a one-hot channel hit, and unmapped.
- The FSM and response register live in the top level.

## Test plan
- RAM read at 0x0001_0010 with ram_dout=0x12345678 -> ram_en pulses, no hold, next-cycle mem_dout=0x12345678.
- ram_busy high for 3 cycles on a RAM write with mem_en=4'b0011 -> mem_hold=1 for 3 cycles, then ram_we=4'b0011 for one cycle.
- Read channel 2 (0xaaaaa800), ack on wait cycle 5 with rdata=0xa5 -> 5 hold cycles, ch_req[2] high 6 cycles, then mem_dout=0xa5.
- Channel 1 never acks with TIMEOUT=8 -> 8 hold cycles, ch_req[1] drops, then mem_dout=0xdeadbeef, mem_err=1, err_cnt=1.
- Write to 0x8000_0000 -> no strobes, no hold, mem_err pulse next cycle; repeat 300 times -> err_cnt saturates at 255.
- rst_n low during CH_WAIT -> ch_req=0 and mem_hold=0 immediately; after release, a fresh RAM read completes normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// ---------------------------------------------------------------------------
// mmio_pkg
// Shared types and constants for the data-side MMIO region router.
//   state_t      : router FSM states (idle, waiting on a channel, abort retire)
//   resp_sel_t   : source selected for mem_dout in the cycle after completion
//   DEF_*        : default MMIO window base and error read data
//   RAM_REGION_* : upper address halves that map to kernel / program RAM
// ---------------------------------------------------------------------------
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CH_WAIT = 2'd1,
        ST_ABORT   = 2'd2
    } state_t;

    // RESP_NONE only exists so mem_dout reads as zero straight out of reset.
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_RAM  = 2'd1,
        RESP_CH   = 2'd2,
        RESP_ERR  = 2'd3
    } resp_sel_t;

    localparam logic [31:0] DEF_MMIO_BASE = 32'haaaaa000;
    localparam logic [31:0] DEF_ERR_DATA  = 32'hdeadbeef;

    localparam logic [15:0] RAM_REGION_KERNEL = 16'h0000;
    localparam logic [15:0] RAM_REGION_PROG   = 16'h0001;

    function automatic logic is_ram_region(input logic [15:0] upper);
        return (upper == RAM_REGION_KERNEL) || (upper == RAM_REGION_PROG);
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// ---------------------------------------------------------------------------
// mmio_addr_decode
// Purely combinational address decode for the MMIO region router.
// Ports:
//   addr     in  32      byte address from the core
//   ram_hit  out 1       address lies in kernel or program RAM
//   ch_hit   out N_CH    one-hot channel window hit
//   unmapped out 1       neither RAM nor any channel window
// ---------------------------------------------------------------------------
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CH_STRIDE = 'h400,
    parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE
) (
    input  logic [31:0]     addr,
    output logic            ram_hit,
    output logic [N_CH-1:0] ch_hit,
    output logic            unmapped
);

    // Window bounds are compared in 64 bits so a window set that ends at or
    // past 4 GiB cannot wrap around and alias low addresses.
    logic [63:0] addr_ext;

    assign addr_ext = {32'd0, addr};

    always_comb begin
        ram_hit = is_ram_region(addr[31:16]);
        ch_hit  = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (!ram_hit &&
                (addr_ext >= (64'(MMIO_BASE) + 64'(k) * 64'(CH_STRIDE))) &&
                (addr_ext <  (64'(MMIO_BASE) + 64'(k + 1) * 64'(CH_STRIDE)))) begin
                ch_hit[k] = 1'b1;
            end
        end
        unmapped = !ram_hit && (ch_hit == '0);
    end

endmodule

// File: rtl/mmio_region_router.sv
// ---------------------------------------------------------------------------
// mmio_region_router
// Routes core load/store accesses to cached RAM or one of N_CH MMIO
// channels, stalling the core while RAM is busy or a channel has not
// acknowledged, and aborting channel accesses after TIMEOUT hold cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_rea/mem_wea       core read / write request (stable while held)
//   mem_en, mem_addr      byte enables, byte address
//   mem_din               write data
//   mem_dout              read data, valid the cycle after completion
//   mem_hold              stall to the core
//   mem_err               one-cycle error pulse aligned with mem_dout
//   err_cnt               saturating count of error pulses
//   ram_en, ram_we        RAM strobe and byte write enables
//   ram_dout, ram_busy    RAM read data (1-cycle latency), cache not ready
//   ch_req                per-channel request, level until ack or abort
//   ch_we/ch_addr/ch_wdata channel write qualifier, window offset, data
//   ch_rdata, ch_ack      per-channel read data and acknowledge
// ---------------------------------------------------------------------------
module mmio_region_router
    import mmio_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CH_STRIDE = 'h400,
    parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA,
    localparam int unsigned AW       = (CH_STRIDE > 1) ? $clog2(CH_STRIDE) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_rea,
    input  logic                 mem_wea,
    input  logic [3:0]           mem_en,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_din,
    output logic [31:0]          mem_dout,
    output logic                 mem_hold,
    output logic                 mem_err,
    output logic [7:0]           err_cnt,
    output logic                 ram_en,
    output logic [3:0]           ram_we,
    input  logic [31:0]          ram_dout,
    input  logic                 ram_busy,
    output logic [N_CH-1:0]      ch_req,
    output logic                 ch_we,
    output logic [AW-1:0]        ch_addr,
    output logic [31:0]          ch_wdata,
    input  logic [32*N_CH-1:0]   ch_rdata,
    input  logic [N_CH-1:0]      ch_ack
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   cnt_inc;
    logic [N_CH-1:0] cur_ch;
    resp_sel_t       resp_sel;
    logic [31:0]     ch_data;

    logic            req;
    logic            ram_hit;
    logic            unmapped;
    logic [N_CH-1:0] ch_hit;
    logic [N_CH-1:0] active_ch;
    logic            ack_hit;
    logic [31:0]     ack_rdata;
    logic            done_ram;
    logic            done_err;

    mmio_addr_decode #(
        .N_CH      (N_CH),
        .CH_STRIDE (CH_STRIDE),
        .MMIO_BASE (MMIO_BASE)
    ) u_decode (
        .addr     (mem_addr),
        .ram_hit  (ram_hit),
        .ch_hit   (ch_hit),
        .unmapped (unmapped)
    );

    // Gating with rst_n makes every strobe and ch_req drop the instant reset
    // asserts, even though the core may still be presenting its request.
    assign req = rst_n & (mem_rea | mem_wea);

    // The channel being driven this cycle: the fresh decode while idle, the
    // latched channel while waiting, nothing during the abort retire cycle.
    always_comb begin
        active_ch = '0;
        if (state == ST_IDLE && req) begin
            active_ch = ch_hit;
        end else if (state == ST_CH_WAIT) begin
            active_ch = cur_ch;
        end
    end

    // Acks from channels that are not being requested are masked off here.
    assign ack_hit = |(active_ch & ch_ack);

    always_comb begin
        ack_rdata = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (active_ch[k]) begin
                ack_rdata = ack_rdata | ch_rdata[k*32 +: 32];
            end
        end
    end

    assign ch_req   = active_ch;
    assign ch_we    = mem_wea & (|active_ch);
    assign ch_addr  = mem_addr[AW-1:0];
    assign ch_wdata = mem_din;

    // wait_cnt counts CH_WAIT cycles already spent; together with the hold
    // in the IDLE decode cycle, reaching TIMEOUT-1 here means TIMEOUT holds.
    assign cnt_inc = wait_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req && (ch_hit != '0) && !ack_hit) begin
                    next_state = (TIMEOUT <= 1) ? ST_ABORT : ST_CH_WAIT;
                end
            end
            ST_CH_WAIT: begin
                if (ack_hit) begin
                    next_state = ST_IDLE;
                end else if (cnt_inc == CW'(TIMEOUT - 1)) begin
                    next_state = ST_ABORT;
                end
            end
            ST_ABORT: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_hold = 1'b0;
        ram_en   = 1'b0;
        ram_we   = '0;
        case (state)
            ST_IDLE: begin
                if (req && ram_hit) begin
                    if (ram_busy) begin
                        mem_hold = 1'b1;
                    end else begin
                        ram_en = 1'b1;
                        ram_we = mem_wea ? mem_en : 4'b0000;
                    end
                end else if (req && !unmapped) begin
                    mem_hold = ~ack_hit;
                end
            end
            ST_CH_WAIT: begin
                mem_hold = ~ack_hit;
            end
            default: begin
                mem_hold = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            cur_ch   <= '0;
        end else begin
            if (state == ST_CH_WAIT && next_state == ST_CH_WAIT) begin
                wait_cnt <= cnt_inc;
            end else begin
                wait_cnt <= '0;
            end
            if (state == ST_IDLE) begin
                cur_ch <= ch_hit;
            end
        end
    end

    assign done_ram = (state == ST_IDLE) && req && ram_hit && !ram_busy;
    assign done_err = ((state == ST_IDLE) && req && unmapped) || (state == ST_ABORT);

    // Response select only moves on a completed access, so mem_dout keeps
    // pointing at the last source while the core is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_sel <= RESP_NONE;
            ch_data  <= '0;
            mem_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            mem_err <= done_err;
            if (done_ram) begin
                resp_sel <= RESP_RAM;
            end else if (ack_hit) begin
                resp_sel <= RESP_CH;
                ch_data  <= ack_rdata;
            end else if (done_err) begin
                resp_sel <= RESP_ERR;
            end
            if (done_err && (err_cnt != 8'hff)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // RAM data is not registered here: the RAM already has one cycle of
    // read latency, so passing ram_dout through lines it up with completion.
    always_comb begin
        case (resp_sel)
            RESP_RAM: mem_dout = ram_dout;
            RESP_CH:  mem_dout = ch_data;
            RESP_ERR: mem_dout = ERR_DATA;
            default:  mem_dout = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_region_router.sv
// ---------------------------------------------------------------------------
// tb_mmio_region_router
// Self-checking bench: directed and random accesses against a transaction
// level reference of the router (region classification, hold/request cycle
// counts, response data and error counting).
// ---------------------------------------------------------------------------
module tb_mmio_region_router;

    localparam int          N_CH      = 4;
    localparam int          CH_STRIDE = 'h400;
    localparam logic [31:0] MMIO_BASE = 32'haaaaa000;
    localparam int          TIMEOUT   = 8;
    localparam logic [31:0] ERR_DATA  = 32'hdeadbeef;
    localparam int          AW        = 10;

    logic                 clk;
    logic                 rst_n;
    logic                 mem_rea;
    logic                 mem_wea;
    logic [3:0]           mem_en;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_din;
    logic [31:0]          mem_dout;
    logic                 mem_hold;
    logic                 mem_err;
    logic [7:0]           err_cnt;
    logic                 ram_en;
    logic [3:0]           ram_we;
    logic [31:0]          ram_dout;
    logic                 ram_busy;
    logic [N_CH-1:0]      ch_req;
    logic                 ch_we;
    logic [AW-1:0]        ch_addr;
    logic [31:0]          ch_wdata;
    logic [32*N_CH-1:0]   ch_rdata;
    logic [N_CH-1:0]      ch_ack;

    int          checks = 0;
    int          errors = 0;
    bit          resp_pending = 0;
    bit          resp_ram = 0;
    logic [31:0] resp_data = '0;
    bit          resp_err = 0;
    int          model_err_cnt = 0;

    mmio_region_router #(
        .N_CH      (N_CH),
        .CH_STRIDE (CH_STRIDE),
        .MMIO_BASE (MMIO_BASE),
        .TIMEOUT   (TIMEOUT),
        .ERR_DATA  (ERR_DATA)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_rea  (mem_rea),
        .mem_wea  (mem_wea),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_hold (mem_hold),
        .mem_err  (mem_err),
        .err_cnt  (err_cnt),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .ram_busy (ram_busy),
        .ch_req   (ch_req),
        .ch_we    (ch_we),
        .ch_addr  (ch_addr),
        .ch_wdata (ch_wdata),
        .ch_rdata (ch_rdata),
        .ch_ack   (ch_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference classification: -1 RAM, k >= 0 channel k, -2 unmapped.
    function automatic int regionOf(input logic [31:0] a);
        longint unsigned ua;
        longint unsigned base;
        logic [15:0]     upper;
        ua    = longint'(a);
        base  = longint'(MMIO_BASE);
        upper = a[31:16];
        if (upper == 16'h0000 || upper == 16'h0001) return -1;
        if (ua >= base && ua < base + N_CH * CH_STRIDE) return int'((ua - base) / CH_STRIDE);
        return -2;
    endfunction

    function automatic void expectError();
        resp_pending = 1;
        resp_ram     = 0;
        resp_data    = ERR_DATA;
        resp_err     = 1;
        if (model_err_cnt < 255) model_err_cnt++;
    endfunction

    task automatic randomizeChannels();
        for (int k = 0; k < N_CH; k++) ch_rdata[k*32 +: 32] = $urandom;
    endtask

    // Waits to the falling edge, where outputs are stable, and checks any
    // response owed from the access that completed on the previous edge.
    task automatic sampleCycle();
        @(negedge clk);
        if (resp_pending) begin
            checkOutput("resp_data", mem_dout, resp_ram ? ram_dout : resp_data);
            checkOutput("resp_err", 32'(mem_err), 32'(resp_err));
            checkOutput("err_cnt", 32'(err_cnt), 32'(model_err_cnt));
            resp_pending = 0;
        end else begin
            checkOutput("no_err_pulse", 32'(mem_err), 32'd0);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_rea  = 1'b0;
            mem_wea  = 1'b0;
            ram_busy = 1'($urandom_range(0, 1));
            ram_dout = $urandom;
            ch_ack   = N_CH'($urandom);
            sampleCycle();
            @(posedge clk);
            #1;
        end
    endtask

    // One complete core access. ackw is the cycle (0 = decode cycle) on which
    // the target channel acks; a negative value means it never acks.
    task automatic applyStimulus(input logic [31:0] addr, input bit wr, input logic [3:0] en,
                                 input logic [31:0] din, input int busy, input int ackw);
        int              region;
        int              exp_hold;
        int              exp_req;
        int              exp_ram_en;
        int              hold_n;
        int              req_n;
        int              bad_n;
        int              ram_en_n;
        int              cyc;
        bit              done;
        bit              ch_ok;
        logic [N_CH-1:0] tgt;
        logic [31:0]     tgt_data;

        region = regionOf(addr);
        tgt    = '0;
        if (region >= 0) tgt[region] = 1'b1;
        ch_ok      = (region >= 0) && (ackw >= 0) && (ackw <= TIMEOUT - 1);
        exp_ram_en = (region == -1) ? 1 : 0;
        if (region == -1) begin
            exp_hold = busy;
            exp_req  = 0;
        end else if (region >= 0) begin
            exp_hold = ch_ok ? ackw : TIMEOUT;
            exp_req  = ch_ok ? ackw + 1 : TIMEOUT;
        end else begin
            exp_hold = 0;
            exp_req  = 0;
        end

        randomizeChannels();
        tgt_data = (region >= 0) ? ch_rdata[region*32 +: 32] : 32'd0;
        mem_addr = addr;
        mem_din  = din;
        mem_en   = en;
        mem_rea  = !wr;
        mem_wea  = wr;
        hold_n   = 0;
        req_n    = 0;
        bad_n    = 0;
        ram_en_n = 0;
        cyc      = 0;
        done     = 0;

        while (!done && cyc < 4 * TIMEOUT + 16) begin
            ram_busy = (region == -1) ? (cyc < busy) : 1'($urandom_range(0, 1));
            ram_dout = $urandom;
            ch_ack   = N_CH'($urandom) & ~tgt;
            if (cyc == ackw) ch_ack = ch_ack | tgt;
            sampleCycle();
            if (mem_hold) hold_n++;
            if (tgt != '0 && ch_req == tgt) begin
                req_n++;
                if (ch_we !== wr || ch_addr !== addr[AW-1:0] || ch_wdata !== din) bad_n++;
            end else if (ch_req != '0) begin
                bad_n++;
            end
            if (ram_en) begin
                ram_en_n++;
                if (ram_we !== (wr ? en : 4'b0000)) bad_n++;
            end else if (ram_we != 4'b0000) begin
                bad_n++;
            end
            if (!mem_hold) begin
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end

        checkOutput("access_completes", 32'(done), 32'd1);
        checkOutput("hold_cycles", 32'(hold_n), 32'(exp_hold));
        checkOutput("ch_req_cycles", 32'(req_n), 32'(exp_req));
        checkOutput("ram_en_pulses", 32'(ram_en_n), 32'(exp_ram_en));
        checkOutput("strobe_fields", 32'(bad_n), 32'd0);

        if (region == -1) begin
            resp_pending = 1;
            resp_ram     = 1;
            resp_err     = 0;
        end else if (ch_ok) begin
            resp_pending = 1;
            resp_ram     = 0;
            resp_data    = tgt_data;
            resp_err     = 0;
        end else begin
            expectError();
        end

        @(posedge clk);
        #1;
        mem_rea = 1'b0;
        mem_wea = 1'b0;
        ch_ack  = '0;
        randomizeChannels();
    endtask

    initial begin
        int          kind;
        int          k;
        int          ackw;
        logic [31:0] addr;

        rst_n    = 1'b0;
        mem_rea  = 1'b0;
        mem_wea  = 1'b0;
        mem_en   = 4'b0000;
        mem_addr = '0;
        mem_din  = '0;
        ram_dout = '0;
        ram_busy = 1'b0;
        ch_rdata = '0;
        ch_ack   = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_hold", 32'(mem_hold), 32'd0);
        checkOutput("rst_err", 32'(mem_err), 32'd0);
        checkOutput("rst_ram_en", 32'(ram_en), 32'd0);
        checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
        checkOutput("rst_ch_req", 32'(ch_req), 32'd0);
        checkOutput("rst_ch_we", 32'(ch_we), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_dout", mem_dout, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed accesses");
        applyStimulus(32'h0001_0010, 1'b0, 4'hf, 32'h0, 0, -1);
        applyStimulus(32'h0000_0100, 1'b1, 4'b0011, 32'h1122_3344, 3, -1);
        applyStimulus(32'haaaa_a800, 1'b0, 4'hf, 32'h0, 0, 5);
        applyStimulus(32'haaaa_a404, 1'b0, 4'hf, 32'h0, 0, -1);
        applyStimulus(32'h8000_0000, 1'b1, 4'hf, 32'h5555_aaaa, 0, -1);
        applyStimulus(32'h0001_fffc, 1'b0, 4'hf, 32'h0, 1, -1);
        applyStimulus(32'h0002_0000, 1'b0, 4'hf, 32'h0, 0, -1);
        applyStimulus(MMIO_BASE - 32'd4, 1'b0, 4'hf, 32'h0, 0, -1);
        applyStimulus(MMIO_BASE, 1'b1, 4'hf, 32'hcafe_0001, 0, 0);
        applyStimulus(MMIO_BASE + 32'(N_CH * CH_STRIDE) - 32'd4, 1'b0, 4'hf, 32'h0, 0, TIMEOUT - 1);
        applyStimulus(MMIO_BASE + 32'(N_CH * CH_STRIDE), 1'b0, 4'hf, 32'h0, 0, -1);
        applyStimulus(MMIO_BASE + 32'(CH_STRIDE), 1'b0, 4'hf, 32'h0, 0, TIMEOUT);
        idleCycles(2);

        $display("[TB] random accesses");
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 3);
            ackw = -1;
            case (kind)
                0: addr = {15'd0, 17'($urandom)};
                1: begin
                    k    = $urandom_range(0, N_CH - 1);
                    addr = MMIO_BASE + 32'(k * CH_STRIDE) + 32'($urandom_range(0, CH_STRIDE - 1));
                    ackw = $urandom_range(0, 3) == 0 ? -1 : $urandom_range(0, TIMEOUT + 1);
                end
                2: addr = MMIO_BASE - 32'($urandom_range(1, 64));
                default: addr = $urandom;
            endcase
            applyStimulus(addr, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                          $urandom_range(0, 3), ackw);
            if ($urandom_range(0, 2) == 0) idleCycles(1);
        end
        idleCycles(1);

        $display("[TB] error counter saturation");
        for (int n = 0; n < 300; n++) begin
            applyStimulus(32'h8000_0000, 1'b1, 4'hf, $urandom, 0, -1);
        end
        idleCycles(1);
        checkOutput("err_cnt_saturated", 32'(err_cnt), 32'd255);

        $display("[TB] reset during channel wait");
        randomizeChannels();
        mem_addr = MMIO_BASE + 32'(CH_STRIDE) + 32'd4;
        mem_rea  = 1'b1;
        mem_wea  = 1'b0;
        ch_ack   = '0;
        ram_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sampleCycle();
            @(posedge clk);
            #1;
        end
        #1;
        checkOutput("wait_ch_req", 32'(ch_req), 32'h2);
        checkOutput("wait_hold", 32'(mem_hold), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_ch_req", 32'(ch_req), 32'd0);
        checkOutput("rst_mid_hold", 32'(mem_hold), 32'd0);
        mem_rea = 1'b0;
        @(negedge clk);
        rst_n         = 1'b1;
        resp_pending  = 0;
        model_err_cnt = 0;
        checkOutput("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(32'h0000_2000, 1'b0, 4'hf, 32'h0, 2, -1);
        idleCycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
